alu_iterative_exec: RTL and testbench
=====================================

// Module: alu_iterative_exec
// PURPOSE
//   Execute-stage ALU directly downstream of the ALU decoder: consumes alu_control[2:0] and shift,
//   performs add/sub/and/or/slt in one cycle and SLL as an iterative one-bit-per-cycle shifter.
//   Uses a start/busy/done handshake so the control path can stall while a shift is in flight.
//   Registered result and zero flag feed writeback and branch logic.
// PARAMETERS
//   WIDTH    32  datapath width of src_a, src_b and result
//   SHAMT_W  5   width of shamt; must satisfy 2**SHAMT_W <= WIDTH
// PORTS
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-high reset
//   start        in   1        request; sampled only when busy=0
//   alu_control  in   3        010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll
//   shift        in   1        1 = shift-type instruction (uses shamt)
//   src_a        in   WIDTH    operand A
//   src_b        in   WIDTH    operand B (the shifted operand for sll)
//   shamt        in   SHAMT_W  shift amount
//   result       out  WIDTH    registered result, held until next completion
//   zero         out  1        registered (result == 0), updated with result
//   busy         out  1        1 while an iterative shift is in progress
//   done         out  1        one-cycle pulse: result/zero valid and newly updated
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-high (reset).
//   - Reset: state IDLE, result=0, zero=1, busy=0, done=0, internal acc/cnt=0.
//   - States: IDLE, SHIFT. busy = (state == SHIFT); done is a register, default 0 each cycle.
//   - IDLE, start=1 sampled at edge E0:
//     * shift=0 or shamt=0: compute op, result/zero loaded at E0, done=1 for the cycle after E0.
//     * shift=1, alu_control=011, shamt=N>0: acc<=src_b, cnt<=N, go SHIFT. Operands captured;
//       later input changes ignored.
//   - SHIFT each edge: acc<=acc<<1, cnt<=cnt-1; when cnt==1: result<=acc<<1, zero updated,
//     done<=1, go IDLE. Latency: done high after edge E0+N (N cycles busy).
//   - shift=0 with shamt!=0 ignores shamt. shift=1 with shamt=0 -> result=src_b, 1-cycle latency.
//   - shift=1 with alu_control!=011: treated as the non-shift op (shamt ignored).
//   - Arithmetic: add/sub modulo 2**WIDTH, no overflow flag; slt signed two's-complement,
//     result = {WIDTH-1 zeros, lt}; sll shifts in zeros, bits past MSB discarded.
//   - Undefined alu_control codes (100, 101): result=0, zero=1, done pulses normally.
//   - start while busy=1: ignored, no queuing. start in the same cycle done=1 (state IDLE): accepted.
//   - Reset asserted mid-shift: immediate return to IDLE, in-flight op dropped, no done pulse.
// CONFIGURATION
//   ALU_BARREL_SHIFT_EN defined: sll computed combinationally (src_b << shamt) with 1-cycle
//   latency like every other op; SHIFT state unused, busy tied 0.
//   Not defined: iterative shifter as above, busy high for shamt cycles.
// TESTING
//   1. add: a=5, b=7, ctrl=010, start 1 cycle -> next cycle done=1, result=12, zero=0, busy never 1.
//   2. sub zero: a=9, b=9, ctrl=110 -> result=0, zero=1; slt: a=-1, b=1, ctrl=111 -> result=1.
//   3. sll: b=0x0000_0003, shamt=4, shift=1, ctrl=011 -> busy 4 cycles, done after 4th edge,
//      result=0x30; with ALU_BARREL_SHIFT_EN: done after 1 edge, busy=0.
//   4. start pulsed while busy (add 1+1) during sll shamt=8 -> ignored; only sll done, one pulse.
//   5. reset asserted 2 cycles into sll shamt=10 -> busy=0, done=0, result=0, zero=1 immediately;
//      following add 2+3 completes with result=5.
//   6. back-to-back: start held high with add ops -> done every cycle, results track inputs by 1.

Source files
------------

// File: rtl/alu_iterative_exec.sv
// alu_iterative_exec
//   Execute-stage ALU. add/sub/and/or/slt complete in one cycle; sll runs as
//   an iterative one-bit-per-cycle shifter behind a start/busy/done handshake.
//   result and zero are registered and held until the next completion.
//
//   Build option: define ALU_BARREL_SHIFT_EN to compute sll combinationally
//   (src_b << shamt) with single-cycle latency; the SHIFT state is then never
//   entered and busy stays 0.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             request, sampled only while busy=0
//   alu_control[2:0]  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll
//   shift             1 = shift-type instruction (uses shamt)
//   src_a, src_b      operands (src_b is the shifted operand for sll)
//   shamt             shift amount
//   result, zero      registered result and (result == 0)
//   busy              1 while an iterative shift is in progress
//   done              one-cycle pulse when result/zero are newly updated
module alu_iterative_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         alu_control,
  input  logic               shift,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   op_res;
  logic               iter_shift;
  logic               lt;

  assign lt = $signed(src_a) < $signed(src_b);

  // Single-cycle result. For the iterative build, code 011 only reaches this
  // path with shift=0 or shamt=0, both of which leave src_b unshifted.
  always_comb begin
    op_res = '0;
    case (alu_control)
      3'b010: op_res = src_a + src_b;
      3'b110: op_res = src_a - src_b;
      3'b000: op_res = src_a & src_b;
      3'b001: op_res = src_a | src_b;
      3'b111: op_res = {{(WIDTH-1){1'b0}}, lt};
`ifdef ALU_BARREL_SHIFT_EN
      3'b011: op_res = shift ? (src_b << shamt) : src_b;
`else
      3'b011: op_res = src_b;
`endif
      default: op_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign iter_shift = 1'b0;
`else
  assign iter_shift = shift && (alu_control == 3'b011) && (shamt != '0);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (iter_shift) begin
            acc_d   = src_b;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - SHAMT_W'(1);
        // Final step writes the last shifted value straight to result.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_q << 1;
          zero_d   = ((acc_q << 1) == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign busy   = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_iterative_exec.sv
module tb_alu_iterative_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  alu_control;
  logic        shift;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  alu_iterative_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .shift(shift), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .result(result), .zero(zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic        sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  amt;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] model_res(input logic [2:0] c, input logic s,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] amt);
    longint unsigned full;
    case (c)
      3'b010: begin full = longint'(a) + longint'(b); return full[31:0]; end
      3'b110: return a + (~b) + 32'd1;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'b011: begin
        if (!s) return b;
        full = longint'(b) * (64'd1 << amt);
        return full[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Edges after the accepting edge before done appears, which equals busy cycles.
  function automatic int model_extra(input logic [2:0] c, input logic s, input logic [4:0] amt);
`ifdef ALU_BARREL_SHIFT_EN
    return 0;
`else
    return (s && c == 3'b011 && amt != 0) ? int'(amt) : 0;
`endif
  endfunction

  task automatic do_op(input logic [2:0] c, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] amt,
                       input logic [31:0] exp_res, input string tag);
    int cyc;
    int busy_n;
    int ext;
    ext = model_extra(c, s, amt);
    @(negedge clk);
    alu_control = c; shift = s; src_a = a; src_b = b; shamt = amt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands: the DUT must have captured them already.
    src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
    cyc = 1; busy_n = 0;
    while (!done && cyc < 64) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc - 1), 32'(ext));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(ext));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses, done_at;
    logic [31:0] res_at;
    logic [31:0] ea, eb;
    logic [2:0] rc;
    logic rs;
    logic [4:0] ramt;

    vecs[0]  = '{3'b010, 1'b0, 32'd5, 32'd7, 5'd0, 32'd12};
    vecs[1]  = '{3'b110, 1'b0, 32'd9, 32'd9, 5'd0, 32'd0};
    vecs[2]  = '{3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1};
    vecs[3]  = '{3'b011, 1'b1, 32'd0, 32'h0000_0003, 5'd4, 32'h30};
    vecs[4]  = '{3'b000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234};
    vecs[5]  = '{3'b001, 1'b0, 32'hF000_0000, 32'h0000_000F, 5'd3, 32'hF000_000F};
    vecs[6]  = '{3'b100, 1'b0, 32'd5, 32'd6, 5'd0, 32'd0};
    vecs[7]  = '{3'b101, 1'b1, 32'd5, 32'd6, 5'd2, 32'd0};
    vecs[8]  = '{3'b011, 1'b1, 32'd0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF};
    vecs[9]  = '{3'b010, 1'b1, 32'd10, 32'd20, 5'd7, 32'd30};
    vecs[10] = '{3'b111, 1'b0, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0};
    vecs[11] = '{3'b110, 1'b0, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF};
    vecs[12] = '{3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0};
    vecs[13] = '{3'b011, 1'b1, 32'd0, 32'h0000_0003, 5'd31, 32'h8000_0000};

    reset = 1'b1; start = 1'b0; alu_control = 3'b000; shift = 1'b0;
    src_a = '0; src_b = '0; shamt = '0;
    #2;
    check("reset result", result, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].ctrl, vecs[i].sh, vecs[i].a, vecs[i].b, vecs[i].amt, vecs[i].exp_res,
            $sformatf("vec%0d", i));

`ifndef ALU_BARREL_SHIFT_EN
    // start pulses while busy must be ignored; exactly one done for the sll.
    @(negedge clk);
    alu_control = 3'b011; shift = 1'b1; src_a = '0; src_b = 32'd1; shamt = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; done_at = -1; res_at = '0;
    for (int i = 0; i < 20; i++) begin
      start = (i < 3);
      alu_control = 3'b010; shift = 1'b0; src_a = 32'd1; src_b = 32'd1;
      @(posedge clk); #1;
      if (done) begin pulses++; done_at = i; res_at = result; end
    end
    start = 1'b0;
    check("busy_ignore pulses", 32'(pulses), 32'd1);
    check("busy_ignore done_edge", 32'(done_at), 32'd7);
    check("busy_ignore result", res_at, 32'h100);

    // Reset in the middle of a shift drops it immediately.
    @(negedge clk);
    alu_control = 3'b011; shift = 1'b1; src_b = 32'd5; shamt = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midreset busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    check("midreset zero", {31'd0, zero}, 32'd1);
    pulses = 0;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midreset no_done", 32'(pulses), 32'd0);
    do_op(3'b010, 1'b0, 32'd2, 32'd3, 5'd0, 32'd5, "after_reset add");
`endif

    // Back-to-back: start held high, results track inputs one cycle later.
    @(negedge clk);
    alu_control = 3'b010; shift = 1'b0; shamt = '0;
    ea = 32'd100; eb = 32'd200; src_a = ea; src_b = eb; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b%0d done", i), {31'd0, done}, 32'd1);
      check($sformatf("b2b%0d result", i), result, ea + eb);
      ea = $urandom; eb = $urandom; src_a = ea; src_b = eb;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b done_drops", {31'd0, done}, 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rc = 3'b011;
      rs = 1'($urandom);
      ramt = 5'($urandom);
      ea = $urandom; eb = $urandom;
      if ($urandom_range(0, 5) == 0) eb = ea;
      do_op(rc, rs, ea, eb, ramt, model_res(rc, rs, ea, eb, ramt), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
